// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port; grant lands 1 cycle after tvalid in IDLE.
// FIFO backpressure passes straight through to the granted requester and freezes grant and beat count.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 128,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s0_tdata,
   input  logic                  s0_tvalid,
   input  logic                  s0_tlast,
   output logic                  s0_tready,
   input  logic [DATA_WIDTH-1:0] s1_tdata,
   input  logic                  s1_tvalid,
   input  logic                  s1_tlast,
   output logic                  s1_tready,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic                  fifo_write_tvalid,
   input  logic                  fifo_write_tready,
   output logic [1:0]            grant,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_BURST);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_inc;
   logic                 r_last_grant;
   logic                 w_last_grant_nxt;
   logic [1:0]           r_grant;
   logic                 w_acc;
   logic                 w_tlast;
   logic                 w_release;

   // On a tie the requester that was not served last wins.
   function automatic state_t f_rr(input logic i_v0, input logic i_v1, input logic i_last);
      state_t w_res;
      w_res = IDLE;
      if (i_v0 && i_v1) begin
         w_res = i_last ? GNT0 : GNT1;
      end else if (i_v0) begin
         w_res = GNT0;
      end else if (i_v1) begin
         w_res = GNT1;
      end
      return w_res;
   endfunction

   always_comb begin
      fifo_wdata        = '0;
      fifo_write_tvalid = 1'b0;
      s0_tready         = 1'b0;
      s1_tready         = 1'b0;
      w_tlast           = 1'b0;
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_last_grant_nxt  = r_last_grant;

      // Datapath follows the registered grant so tready drops the instant reset clears it.
      if (r_grant[0]) begin
         fifo_wdata        = s0_tdata;
         fifo_write_tvalid = s0_tvalid;
         s0_tready         = fifo_write_tready;
         w_tlast           = s0_tlast;
      end else if (r_grant[1]) begin
         fifo_wdata        = s1_tdata;
         fifo_write_tvalid = s1_tvalid;
         s1_tready         = fifo_write_tready;
         w_tlast           = s1_tlast;
      end

      w_acc     = fifo_write_tvalid && fifo_write_tready;
      w_cnt_inc = r_cnt + 1'b1;
      w_release = w_acc && (w_tlast || (w_cnt_inc == LP_MAX));

      unique case (r_state)
         IDLE: begin
            w_state_nxt = f_rr(s0_tvalid, s1_tvalid, r_last_grant);
            w_cnt_nxt   = '0;
         end
         GNT0, GNT1: begin
            if (w_release) begin
               w_last_grant_nxt = (r_state == GNT1);
               w_state_nxt      = f_rr(s0_tvalid, s1_tvalid, w_last_grant_nxt);
               w_cnt_nxt        = '0;
            end else if (w_acc) begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_grant      <= 2'b00;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_grant      <= {w_state_nxt == GNT1, w_state_nxt == GNT0};
      end
   end

   assign grant = r_grant;
   assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level owner/count model.
module tb_fifo_wr_arbiter;

   localparam int DW   = 128;
   localparam int MAXB = 4;
   localparam int CW   = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s0_tdata, s1_tdata, fifo_wdata;
   logic          s0_tvalid, s0_tlast, s0_tready;
   logic          s1_tvalid, s1_tlast, s1_tready;
   logic          fifo_write_tvalid, fifo_write_tready;
   logic [1:0]    grant;
   logic          busy;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAXB), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
      .fifo_wdata(fifo_wdata), .fifo_write_tvalid(fifo_write_tvalid),
      .fifo_write_tready(fifo_write_tready), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef logic [DW:0] beat_t;   // {tlast, tdata}

   int            n_checks = 0;
   int            n_pass   = 0;
   int            seq      = 0;
   beat_t         q0[$];
   beat_t         q1[$];
   logic [DW-1:0] exp_q[$];
   logic          held0 = 1'b0, held1 = 1'b0, hs0 = 1'b0, hs1 = 1'b0;
   int            m_owner = -1;   // -1 idle, else index of the requester holding the port
   int            m_last  = 1;
   int            m_cnt   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   function automatic int rr(input logic v0, input logic v1, input int last);
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic add_pkt(input int src, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b[DW-1:0] = {8'(src), 24'(seq), $urandom, $urandom, $urandom};
         b[DW]     = (i == len - 1);
         seq++;
         if (src == 0) q0.push_back(b);
         else q1.push_back(b);
      end
   endtask

   task automatic step(input int vprob, input int rprob);
      logic          v0, v1, l0, l1, rdy, acc, ev, er0, er1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    eg;
      @(negedge clk);
      if (hs0) begin q0.delete(0); held0 = 1'b0; end
      if (hs1) begin q1.delete(0); held1 = 1'b0; end
      if (!held0 && q0.size() > 0 && int'($urandom_range(99)) < vprob) held0 = 1'b1;
      if (!held1 && q1.size() > 0 && int'($urandom_range(99)) < vprob) held1 = 1'b1;
      s0_tvalid = held0;
      s0_tdata  = held0 ? q0[0][DW-1:0] : {$urandom, $urandom, $urandom, $urandom};
      s0_tlast  = held0 ? q0[0][DW] : 1'($urandom);
      s1_tvalid = held1;
      s1_tdata  = held1 ? q1[0][DW-1:0] : {$urandom, $urandom, $urandom, $urandom};
      s1_tlast  = held1 ? q1[0][DW] : 1'($urandom);
      fifo_write_tready = (int'($urandom_range(99)) < rprob);
      #1;
      v0 = s0_tvalid; v1 = s1_tvalid; l0 = s0_tlast; l1 = s1_tlast;
      d0 = s0_tdata;  d1 = s1_tdata;  rdy = fifo_write_tready;
      eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      er0 = (m_owner == 0) && rdy;
      er1 = (m_owner == 1) && rdy;
      ev  = (m_owner == 0) ? v0 : (m_owner == 1) ? v1 : 1'b0;
      check("grant_busy_ready_valid", DW'({grant, busy, s0_tready, s1_tready, fifo_write_tvalid}),
            DW'({eg, m_owner >= 0, er0, er1, ev}));
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      if (m_owner < 0) begin
         m_owner = rr(v0, v1, m_last);
         m_cnt   = 0;
      end else begin
         acc = ((m_owner == 0) ? v0 : v1) && rdy;
         if (acc) begin
            exp_q.push_back((m_owner == 0) ? d0 : d1);
            m_cnt++;
            if (((m_owner == 0) ? l0 : l1) || m_cnt == MAXB) begin
               m_last  = m_owner;
               m_owner = rr(v0, v1, m_owner);
               m_cnt   = 0;
            end
         end
      end
   endtask

   task automatic drain(input int vprob, input int rprob);
      int cyc = 0;
      while ((q0.size() > 0 || q1.size() > 0) && cyc < 3000) begin
         step(vprob, rprob);
         cyc++;
      end
      n_checks++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL drain_timeout: %0d/%0d beats still queued, required 0/0", q0.size(), q1.size());
   endtask

   task automatic async_reset_check();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("rst_grant", DW'(grant), DW'(2'b00));
      check("rst_ready_valid_busy", DW'({s0_tready, s1_tready, fifo_write_tvalid, busy}), DW'(4'b0000));
      check("rst_wdata", fifo_wdata, '0);
      q0.delete(); q1.delete();
      held0 = 1'b0; held1 = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; fifo_write_tready = 1'b0;
      m_owner = -1; m_last = 1; m_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every FIFO write must match the next model prediction.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset && fifo_write_tvalid && fifo_write_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL fifo_unexpected: got write %h, required no write", fifo_wdata);
            end else begin
               check("fifo_wdata", fifo_wdata, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
      s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
      fifo_write_tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("init_grant", DW'(grant), DW'(2'b00));
      check("init_ready_valid_busy", DW'({s0_tready, s1_tready, fifo_write_tvalid, busy}), DW'(4'b0000));
      check("init_wdata", fifo_wdata, '0);
      @(negedge clk);
      reset = 1'b1;

      // Tie right after reset: s0 first, s1 handed over without a bubble.
      add_pkt(0, 2); add_pkt(1, 2);
      drain(100, 100);
      // Single-beat packets on both sides: beat-level alternation.
      repeat (4) begin add_pkt(0, 1); add_pkt(1, 1); end
      drain(100, 100);
      // FIFO full while s0 holds the port.
      add_pkt(0, 3);
      repeat (6) step(100, 0);
      drain(100, 100);
      // Burst cap: 6-beat s1 packet is split after MAXB beats.
      add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 6);
      drain(100, 100);
      // Random traffic; both queues kept non-empty so a held grant always gets a beat.
      for (int i = 0; i < 600; i++) begin
         if (q0.size() < 2) add_pkt(0, $urandom_range(1, 7));
         if (q1.size() < 2) add_pkt(1, $urandom_range(1, 7));
         step(70, 60);
      end
      async_reset_check();
      // Reset mid-packet while s1 owns a stalled port.
      add_pkt(1, 3);
      repeat (3) step(100, 0);
      check("gnt1_before_reset", DW'(grant), DW'(2'b10));
      async_reset_check();
      // First tie after reset goes to s0 again.
      add_pkt(0, 1); add_pkt(1, 1);
      drain(100, 100);
      repeat (3) step(0, 100);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_leftover: %0d predicted writes never seen, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Two-requester, packet-aware round-robin arbiter that shares the single write port of the 128-bit block-RAM FIFO.
- Sits between the AES core output stream (requester 0) and the bypass/passthrough stream (requester 1), and the FIFO write port.
- Grants are held for a whole packet, ending at tlast, or for at most MAX_BURST beats, so neither requester can starve the other.

Parameters:
- DATA_WIDTH, 128, beat width; matches the FIFO data width.
- MAX_BURST, 16, maximum accepted beats per grant before forced re-arbitration; legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 5, beat counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s0_tdata  in  DATA_WIDTH  requester 0 data.
- s0_tvalid  in  1  requester 0 valid.
- s0_tlast  in  1  requester 0 last beat of packet.
- s0_tready  out  1  requester 0 ready.
- s1_tdata  in  DATA_WIDTH  requester 1 data.
- s1_tvalid  in  1  requester 1 valid.
- s1_tlast  in  1  requester 1 last beat of packet.
- s1_tready  out  1  requester 1 ready.
- fifo_wdata  out  DATA_WIDTH  to FIFO write data.
- fifo_write_tvalid  out  1  to FIFO write valid.
- fifo_write_tready  in  1  from FIFO write ready; may depend combinationally on fifo_write_tvalid.
- grant  out  2  one-hot current grant; 2'b00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asserted when reset=0, asynchronously. Reset values:
  - state=IDLE, grant=00, busy=0, beat counter=0.
  - last_grant=1, so requester 0 wins the first tie.
  - s0_tready=s1_tready=0 and fifo_write_tvalid=0, because these are combinational from grant.
- States: IDLE, GNT0, GNT1. grant is the one-hot registered decode of the state.
- Datapath is combinational while granted to requester N:
  - fifo_wdata=sN_tdata.
  - fifo_write_tvalid=sN_tvalid.
  - sN_tready=fifo_write_tready.
  - The other requester's tready=0.
- In IDLE: fifo_write_tvalid=0, both treadys=0, fifo_wdata=0.
- A beat is accepted when sN_tvalid && sN_tready. tvalid never depends on tready, so there is no combinational loop through the FIFO.
- IDLE transitions (evaluated each cycle):
  - Only s0_tvalid -> GNT0.
  - Only s1_tvalid -> GNT1.
  - Both valid -> the requester that is not last_grant.
  - Neither -> stay in IDLE.
  - Grant latency: 1 cycle from tvalid in IDLE until tready can be high.
- Beat counter:
  - Cleared on every entry into GNT0/GNT1.
  - Incremented on each accepted beat.
- Release condition in GNTn: an accepted beat with sN_tlast=1, or an accepted beat that makes the count reach MAX_BURST.
- On the release cycle:
  - last_grant <= n.
  - Next state follows the same round-robin rule as IDLE, using the tvalids sampled that cycle. This gives zero-bubble handover: if the other requester is valid it is granted on the next cycle.
  - If neither requester is valid, next state is IDLE.
  - If only the same requester is valid, it is re-granted with the counter cleared.
- No release without an accepted beat:
  - Deasserting sN_tvalid mid-packet holds the grant.
  - FIFO full (fifo_write_tready=0) holds the grant and the counter.
- MAX_BURST=1 degenerates to beat-level round-robin.
- A forced release mid-packet is legal. The packet resumes on the requester's next grant; packet integrity in the FIFO is not guaranteed across requesters in that case. Software sizes packets <= MAX_BURST when integrity is required.
- Reset mid-packet: immediate return to IDLE. The beat presented during reset is not accepted. The partial packet is abandoned and no recovery is attempted.
- tdata of the non-granted requester never reaches fifo_wdata.

Test Plan:
- Single requester: s0 sends 3 beats (A0,A1,A2, tlast on A2), FIFO ready -> grant=01 one cycle after s0_tvalid; 3 consecutive accepts; return to IDLE; FIFO reads back A0,A1,A2.
- Contention tie after reset: s0 and s1 both valid at the same cycle with 2-beat packets -> s0 granted first, then s1 granted on the cycle immediately after s0's tlast beat (no idle cycle); FIFO order A0,A1,B0,B1.
- Fairness: both requesters continuously valid with 1-beat packets -> grant alternates 01,10,01,10 every accepted beat.
- Burst cap: MAX_BURST=4, s1 sends a 6-beat packet while s0 is valid -> after s1 beat 4, s0 is granted; s1 beats 5-6 follow s0's packet.
- Backpressure: FIFO fills (fifo_full=1) during a GNT0 packet -> s0_tready=0; grant and counter held; resumes when a FIFO read frees space, with no lost or duplicated beats.
- Async reset: assert reset=0 mid-cycle in GNT1 -> grant=00, s1_tready=0 and fifo_write_tvalid=0 immediately, without waiting for a clock edge; after release of reset, the first tie goes to s0.
